// File: rtl/bram_stream_reader.sv
// Streams a BRAM port-B word range as bytes (MSB first) on a valid/ready link to the UART transmitter.
// Define BRAM_STREAM_CHECKSUM_EN to append a 16-bit sum of the streamed words after the data bytes.
module bram_stream_reader #(
    parameter int ADDR_W     = 12,
    parameter int DATA_W     = 16,
    parameter int RD_LATENCY = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   len,
    output logic [ADDR_W-1:0] addrb,
    input  logic [DATA_W-1:0] doutb,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        HI    = 3'd3,
        LO    = 3'd4,
`ifdef BRAM_STREAM_CHECKSUM_EN
        CK_HI = 3'd5,
        CK_LO = 3'd6,
`endif
        FIN   = 3'd7
    } state_t;

    localparam logic [1:0]        LAT_LAST = 2'(RD_LATENCY - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   CNT_ZERO = {(ADDR_W+1){1'b0}};

`ifdef BRAM_STREAM_CHECKSUM_EN
    function automatic logic [15:0] csum_add(input logic [15:0] acc, input logic [15:0] word);
        return acc + word;
    endfunction
`endif

    state_t              state_r, state_s;
    logic [ADDR_W-1:0]   addr_r, addr_s;
    logic [ADDR_W:0]     cnt_r, cnt_s;
    logic [DATA_W-1:0]   word_r, word_s;
    logic [1:0]          lat_r, lat_s;
    logic [7:0]          tx_data_r, tx_data_s;
    logic                tx_valid_r, tx_valid_s;
    logic                busy_r, busy_s;
    logic                done_r, done_s;
    logic                hs_s;
`ifdef BRAM_STREAM_CHECKSUM_EN
    logic [15:0]         csum_r, csum_s;
`endif

    assign addrb    = addr_r;
    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign busy     = busy_r;
    assign done     = done_r;

    // Next-state, datapath updates and next values of the registered outputs
    always_comb begin
        state_s   = state_r;
        addr_s    = addr_r;
        cnt_s     = cnt_r;
        word_s    = word_r;
        lat_s     = lat_r;
        tx_data_s = tx_data_r;
`ifdef BRAM_STREAM_CHECKSUM_EN
        csum_s    = csum_r;
`endif
        hs_s      = tx_valid_r & tx_ready;

        case (state_r)
            IDLE: begin
                if (start) begin
                    addr_s = base_addr;
                    cnt_s  = len;
`ifdef BRAM_STREAM_CHECKSUM_EN
                    csum_s = 16'h0000;
`endif
                    if (len == CNT_ZERO) begin
`ifdef BRAM_STREAM_CHECKSUM_EN
                        state_s   = CK_HI;
                        tx_data_s = 8'h00;
`else
                        state_s   = FIN;
`endif
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            FETCH: begin
                lat_s   = 2'd0;
                state_s = WAIT;
            end
            // addrb has been stable since FETCH; doutb is valid after RD_LATENCY WAIT cycles
            WAIT: begin
                if (lat_r == LAT_LAST) begin
                    word_s    = doutb;
                    tx_data_s = doutb[15:8];
                    state_s   = HI;
                end else begin
                    lat_s = lat_r + 2'd1;
                end
            end
            HI: begin
                if (hs_s) begin
                    tx_data_s = word_r[7:0];
                    state_s   = LO;
                end else begin
                    state_s = HI;
                end
            end
            LO: begin
                if (hs_s) begin
                    cnt_s  = cnt_r - CNT_ONE;
                    addr_s = addr_r + ADDR_ONE;
`ifdef BRAM_STREAM_CHECKSUM_EN
                    csum_s = csum_add(csum_r, word_r);
`endif
                    if (cnt_r == CNT_ONE) begin
`ifdef BRAM_STREAM_CHECKSUM_EN
                        state_s   = CK_HI;
                        tx_data_s = csum_s[15:8];
`else
                        state_s   = FIN;
`endif
                    end else begin
                        state_s = FETCH;
                    end
                end else begin
                    state_s = LO;
                end
            end
`ifdef BRAM_STREAM_CHECKSUM_EN
            CK_HI: begin
                if (hs_s) begin
                    tx_data_s = csum_r[7:0];
                    state_s   = CK_LO;
                end else begin
                    state_s = CK_HI;
                end
            end
            CK_LO: begin
                if (hs_s) begin
                    state_s = FIN;
                end else begin
                    state_s = CK_LO;
                end
            end
`endif
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        case (state_s)
            HI, LO:       tx_valid_s = 1'b1;
`ifdef BRAM_STREAM_CHECKSUM_EN
            CK_HI, CK_LO: tx_valid_s = 1'b1;
`endif
            default:      tx_valid_s = 1'b0;
        endcase

        busy_s = (state_s != IDLE);
        done_s = (state_r == FIN);
    end

    // State, datapath and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= IDLE;
            addr_r     <= {ADDR_W{1'b0}};
            cnt_r      <= CNT_ZERO;
            word_r     <= {DATA_W{1'b0}};
            lat_r      <= 2'd0;
            tx_data_r  <= 8'h00;
            tx_valid_r <= 1'b0;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
`ifdef BRAM_STREAM_CHECKSUM_EN
            csum_r     <= 16'h0000;
`endif
        end else begin
            state_r    <= state_s;
            addr_r     <= addr_s;
            cnt_r      <= cnt_s;
            word_r     <= word_s;
            lat_r      <= lat_s;
            tx_data_r  <= tx_data_s;
            tx_valid_r <= tx_valid_s;
            busy_r     <= busy_s;
            done_r     <= done_s;
`ifdef BRAM_STREAM_CHECKSUM_EN
            csum_r     <= csum_s;
`endif
        end
    end

endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed self-checking bench for bram_stream_reader with a 1-cycle BRAM port-B model.
// Expectations follow BRAM_STREAM_CHECKSUM_EN when it is defined for the build.
module tb_bram_stream_reader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [11:0] base_addr;
    logic [12:0] len;
    logic [11:0] addrb;
    logic [15:0] doutb;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        busy;
    logic        done;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [15:0] mem [0:4095];
    logic [7:0]  got_q[$];
    logic [7:0]  exp_q[$];
    int          done_cnt   = 0;
    int          stall_err  = 0;
    logic        prev_stall = 1'b0;
    logic [7:0]  prev_data  = 8'h00;
    int          b0, d0, s0, low, n;

    bram_stream_reader dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .base_addr (base_addr),
        .len       (len),
        .addrb     (addrb),
        .doutb     (doutb),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    // BRAM port B, read latency 1
    always @(posedge clk) doutb <= mem[addrb];

    // Byte capture, done counting and hold-while-stalled tracking
    always @(posedge clk) begin
        if (rst) begin
            prev_stall <= 1'b0;
        end else begin
            if (prev_stall && (!tx_valid || tx_data !== prev_data)) stall_err <= stall_err + 1;
            if (tx_valid && tx_ready) got_q.push_back(tx_data);
            if (done) done_cnt <= done_cnt + 1;
            prev_stall <= tx_valid && !tx_ready;
            prev_data  <= tx_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic wait_done(input int budget, input string tag);
        int k = 0;
        while (done !== 1'b1 && k < budget) begin
            tick();
            k++;
        end
        check({tag, "_done_seen"}, {31'd0, done}, 32'd1);
        check({tag, "_busy_at_done"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic expect_bytes(input string tag, input int base);
        check({tag, "_nbytes"}, got_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            if (base + i < got_q.size())
                check($sformatf("%s_byte%0d", tag, i), {24'd0, got_q[base+i]}, {24'd0, exp_q[i]});
        end
    endtask

    task automatic pulse_start(input logic [11:0] b, input logic [12:0] l);
        base_addr = b;
        len       = l;
        start     = 1'b1;
        tick();
        start     = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; base_addr = 12'd0; len = 13'd0; tx_ready = 1'b0;
        for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
        mem[5]  = 16'h1234; mem[6]  = 16'hABCD;
        mem[4095] = 16'hFFFF; mem[0] = 16'h0001;
        mem[10] = 16'hA55A; mem[11] = 16'h0F0F; mem[12] = 16'h1357;
        mem[20] = 16'h1111; mem[21] = 16'h2222; mem[22] = 16'h3333; mem[23] = 16'h4444;
        mem[30] = 16'hC001; mem[31] = 16'hC002; mem[32] = 16'hC003; mem[33] = 16'hC004;
        tick(); tick();
        check("rst_addrb",    {20'd0, addrb},    32'd0);
        check("rst_tx_data",  {24'd0, tx_data},  32'd0);
        check("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        check("rst_busy",     {31'd0, busy},     32'd0);
        check("rst_done",     {31'd0, done},     32'd0);
        rst = 1'b0;
        tick();

        // Basic two-word read, ready held high
        tx_ready = 1'b1; b0 = got_q.size(); d0 = done_cnt;
        pulse_start(12'd5, 13'd2);
        check("t1_busy",  {31'd0, busy},  32'd1);
        check("t1_addrb", {20'd0, addrb}, 32'd5);
        tick();
        check("t1_valid_early", {31'd0, tx_valid}, 32'd0);
        tick();
        check("t1_valid_lat", {31'd0, tx_valid}, 32'd1);
        check("t1_first",     {24'd0, tx_data},  32'h12);
        wait_done(40, "t1");
        tick();
        check("t1_done_pulse", {31'd0, done}, 32'd0);
        exp_q = {8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef BRAM_STREAM_CHECKSUM_EN
        exp_q.push_back(8'hBE); exp_q.push_back(8'h01);
`endif
        expect_bytes("t1", b0);
        check("t1_done_cnt", done_cnt - d0, 32'd1);

        // Address wrap from 4095 to 0
        b0 = got_q.size();
        pulse_start(12'd4095, 13'd2);
        check("t2_addr_first", {20'd0, addrb}, 32'd4095);
        tick(); tick(); tick(); tick();
        check("t2_addr_wrap",  {20'd0, addrb},    32'd0);
        check("t2_fetch_idle", {31'd0, tx_valid}, 32'd0);
        wait_done(40, "t2");
        tick();
        exp_q = {8'hFF, 8'hFF, 8'h00, 8'h01};
`ifdef BRAM_STREAM_CHECKSUM_EN
        exp_q.push_back(8'h00); exp_q.push_back(8'h00);
`endif
        expect_bytes("t2", b0);

        // Backpressure on a three-word read
        b0 = got_q.size(); s0 = stall_err; tx_ready = 1'b0;
        pulse_start(12'd10, 13'd3);
        tick(); tick();
        check("t3_hold_valid0", {31'd0, tx_valid}, 32'd1);
        check("t3_hold_data0",  {24'd0, tx_data},  32'hA5);
        tick();
        check("t3_hold_valid1", {31'd0, tx_valid}, 32'd1);
        check("t3_hold_data1",  {24'd0, tx_data},  32'hA5);
        low = 3; n = 0;
        while (done !== 1'b1 && n < 300) begin
            if (low < 5 && $urandom_range(0, 1) == 1) begin
                tx_ready = 1'b0; low++;
            end else begin
                tx_ready = 1'b1; low = 0;
            end
            tick();
            n++;
        end
        check("t3_done_seen", {31'd0, done}, 32'd1);
        tx_ready = 1'b1;
        tick();
        exp_q = {8'hA5, 8'h5A, 8'h0F, 8'h0F, 8'h13, 8'h57};
`ifdef BRAM_STREAM_CHECKSUM_EN
        exp_q.push_back(8'hC7); exp_q.push_back(8'hC0);
`endif
        expect_bytes("t3", b0);
        check("t3_stall_stable", stall_err - s0, 32'd0);

        // Zero-length request
        b0 = got_q.size(); d0 = done_cnt;
        pulse_start(12'd7, 13'd0);
`ifdef BRAM_STREAM_CHECKSUM_EN
        check("t4_ck_valid", {31'd0, tx_valid}, 32'd1);
        check("t4_ck_data",  {24'd0, tx_data},  32'h00);
        wait_done(20, "t4");
        tick();
        exp_q = {8'h00, 8'h00};
`else
        check("t4_no_valid", {31'd0, tx_valid}, 32'd0);
        check("t4_done_early", {31'd0, done}, 32'd0);
        tick();
        check("t4_done_2cyc", {31'd0, done}, 32'd1);
        check("t4_busy_low",  {31'd0, busy}, 32'd0);
        tick();
        exp_q = {};
`endif
        expect_bytes("t4", b0);
        check("t4_done_cnt", done_cnt - d0, 32'd1);

        // A second start during a four-word read is dropped
        b0 = got_q.size(); d0 = done_cnt;
        pulse_start(12'd20, 13'd4);
        tick(); tick(); tick(); tick();
        pulse_start(12'd0, 13'd1);
        wait_done(80, "t5");
        for (int i = 0; i < 10; i++) tick();
        check("t5_done_cnt", done_cnt - d0, 32'd1);
        check("t5_idle_busy", {31'd0, busy}, 32'd0);
        exp_q = {8'h11, 8'h11, 8'h22, 8'h22, 8'h33, 8'h33, 8'h44, 8'h44};
`ifdef BRAM_STREAM_CHECKSUM_EN
        exp_q.push_back(8'hAA); exp_q.push_back(8'hAA);
`endif
        expect_bytes("t5", b0);

        // Asynchronous reset in LO of word 2 of 4, then a fresh read
        d0 = done_cnt;
        pulse_start(12'd30, 13'd4);
        for (int i = 0; i < 7; i++) tick();
        check("t6_in_lo_valid", {31'd0, tx_valid}, 32'd1);
        check("t6_in_lo_data",  {24'd0, tx_data},  32'h02);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", {31'd0, tx_valid}, 32'd0);
        check("t6_rst_busy",  {31'd0, busy},     32'd0);
        check("t6_rst_done",  {31'd0, done},     32'd0);
        check("t6_rst_addrb", {20'd0, addrb},    32'd0);
        tick();
        rst = 1'b0;
        tick(); tick();
        check("t6_no_done", done_cnt - d0, 32'd0);
        b0 = got_q.size();
        pulse_start(12'd0, 13'd1);
        wait_done(40, "t6");
        tick();
        exp_q = {8'h00, 8'h01};
`ifdef BRAM_STREAM_CHECKSUM_EN
        exp_q.push_back(8'h00); exp_q.push_back(8'h01);
`endif
        expect_bytes("t6", b0);
        check("t6_done_cnt", done_cnt - d0, 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
